trigger_surround_cache_p: RTL and testbench

//  Parametrised trigger-surround capture cache for the ADC front end. Continuously

---
 rtl/trigger_surround_cache_p.sv | 196 +++++++++++++++++++
 tb/tb_trigger_surround_cache_p.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_surround_cache_p.sv
// Trigger-surround capture cache: rings ADC samples, detects a level/rising trigger,
// freezes a DEPTH-sample window around it and shifts the window out serially, MSB first.
module trigger_surround_cache_p #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned PRE     = 16,
   parameter int unsigned TIMER_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               adc_rdy_i,
   input  logic [DATA_W-1:0]  adc_data_i,
   input  logic [DATA_W-1:0]  trig_level_i,
   input  logic               trig_mode_i,
   input  logic               sbf_i,
   output logic               busy_o,
   output logic               trd_o,
   output logic [TIMER_W-1:0] trigtm_o,
   output logic               sd_o,
   output logic               sd_valid_o,
   output logic               cd_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {StIdle, StFill, StArmed, StPost, StHold, StSend} state_e;

   state_e              state_q, state_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_ptr_q, trig_ptr_d;
   logic [PtrW-1:0]     pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d, word_cnt_q, word_cnt_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   prev_q, prev_d, shreg_q, shreg_d;
   logic [TIMER_W-1:0]  timer_q, timer_d, trigtm_q, trigtm_d;
   logic                trd_q, trd_d, cd_q, cd_d, sd_valid_q, sd_valid_d;
   logic [DATA_W-1:0]   ring_q [DEPTH];
   logic                ring_we, start_ok, trig_hit;
   logic [PtrW-1:0]     rd_start, rd_nxt;

   assign start_ok = start_i && (state_q == StIdle || state_q == StHold);
   assign trig_hit = trig_mode_i ? (prev_q < trig_level_i && adc_data_i >= trig_level_i)
                                 : (adc_data_i >= trig_level_i);
   // Oldest kept sample sits PRE entries behind the trigger slot.
   assign rd_start = trig_ptr_q - PtrW'(PRE);
   assign rd_nxt   = rd_ptr_q + PtrW'(1);

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      trig_ptr_d = trig_ptr_q;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      word_cnt_d = word_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      prev_d     = prev_q;
      shreg_d    = shreg_q;
      timer_d    = timer_q;
      trigtm_d   = trigtm_q;
      trd_d      = trd_q;
      cd_d       = cd_q;
      sd_valid_d = sd_valid_q;
      ring_we    = 1'b0;

      if ((state_q == StFill || state_q == StArmed || state_q == StPost) && timer_q != '1) begin
         timer_d = timer_q + TIMER_W'(1);
      end

      if (start_ok) begin
         trd_d     = 1'b0;
         cd_d      = 1'b0;
         trigtm_d  = '0;
         timer_d   = '0;
         wr_ptr_d  = '0;
         pre_cnt_d = '0;
         prev_d    = '0;
         state_d   = StFill;
      end else begin
         unique case (state_q)
            StIdle: ;
            StFill: begin
               if (adc_rdy_i) begin
                  ring_we   = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PtrW'(1);
                  prev_d    = adc_data_i;
                  pre_cnt_d = pre_cnt_q + PtrW'(1);
                  if (pre_cnt_q == PtrW'(PRE - 1)) state_d = StArmed;
               end
            end
            StArmed: begin
               if (adc_rdy_i) begin
                  ring_we  = 1'b1;
                  wr_ptr_d = wr_ptr_q + PtrW'(1);
                  prev_d   = adc_data_i;
                  if (trig_hit) begin
                     trd_d      = 1'b1;
                     trigtm_d   = timer_q;
                     trig_ptr_d = wr_ptr_q;
                     post_cnt_d = '0;
                     state_d    = StPost;
                  end
               end
            end
            StPost: begin
               if (adc_rdy_i) begin
                  ring_we    = 1'b1;
                  wr_ptr_d   = wr_ptr_q + PtrW'(1);
                  prev_d     = adc_data_i;
                  post_cnt_d = post_cnt_q + PtrW'(1);
                  if (post_cnt_q == PtrW'(DEPTH - PRE - 2)) state_d = StHold;
               end
            end
            StHold: begin
               if (sbf_i) begin
                  rd_ptr_d   = rd_start;
                  shreg_d    = ring_q[rd_start];
                  word_cnt_d = '0;
                  bit_cnt_d  = '0;
                  sd_valid_d = 1'b1;
                  state_d    = StSend;
               end
            end
            StSend: begin
               if (bit_cnt_q == BitW'(DATA_W - 1)) begin
                  if (word_cnt_q == PtrW'(DEPTH - 1)) begin
                     sd_valid_d = 1'b0;
                     shreg_d    = '0;
                     cd_d       = 1'b1;
                     state_d    = StHold;
                  end else begin
                     rd_ptr_d   = rd_nxt;
                     shreg_d    = ring_q[rd_nxt];
                     word_cnt_d = word_cnt_q + PtrW'(1);
                     bit_cnt_d  = '0;
                  end
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q + BitW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         trig_ptr_q <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         word_cnt_q <= '0;
         bit_cnt_q  <= '0;
         prev_q     <= '0;
         shreg_q    <= '0;
         timer_q    <= '0;
         trigtm_q   <= '0;
         trd_q      <= 1'b0;
         cd_q       <= 1'b0;
         sd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         trig_ptr_q <= trig_ptr_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         word_cnt_q <= word_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         prev_q     <= prev_d;
         shreg_q    <= shreg_d;
         timer_q    <= timer_d;
         trigtm_q   <= trigtm_d;
         trd_q      <= trd_d;
         cd_q       <= cd_d;
         sd_valid_q <= sd_valid_d;
      end
   end

   // Sample storage carries no reset; contents are only read after a full capture.
   always_ff @(posedge clk_i) begin
      if (ring_we) ring_q[wr_ptr_q] <= adc_data_i;
   end

   assign busy_o     = (state_q == StFill) || (state_q == StArmed) ||
                       (state_q == StPost) || (state_q == StSend);
   assign trd_o      = trd_q;
   assign trigtm_o   = trigtm_q;
   assign cd_o       = cd_q;
   assign sd_valid_o = sd_valid_q;
   assign sd_o       = sd_valid_q & shreg_q[DATA_W-1];

endmodule

// File: tb/tb_trigger_surround_cache_p.sv
// Bench for trigger_surround_cache_p: builds sample sequences, queues the expected window
// at capture time and checks the serial stream word by word as it arrives.
module tb_trigger_surround_cache_p;

   localparam int DW  = 8;
   localparam int DEP = 32;
   localparam int PR  = 16;
   localparam int TW  = 32;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          start = 1'b0, adc_rdy = 1'b0, trig_mode = 1'b0, sbf = 1'b0;
   logic [DW-1:0] adc_data = '0, trig_level = '0;
   logic          busy, trd, sd, sd_valid, cd;
   logic [TW-1:0] trigtm;

   int total = 0, bad = 0;
   int cyc = 0;
   int smp_cyc;
   logic [DW-1:0] seq_q[$];
   logic [DW-1:0] exp_q[$];

   trigger_surround_cache_p #(.DATA_W(DW), .DEPTH(DEP), .PRE(PR), .TIMER_W(TW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .adc_rdy_i(adc_rdy), .adc_data_i(adc_data),
      .trig_level_i(trig_level), .trig_mode_i(trig_mode), .sbf_i(sbf), .busy_o(busy),
      .trd_o(trd), .trigtm_o(trigtm), .sd_o(sd), .sd_valid_o(sd_valid), .cd_o(cd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_sample(input logic [DW-1:0] d);
      @(negedge clk);
      adc_data = d;
      adc_rdy  = 1'b1;
      @(negedge clk);
      adc_rdy = 1'b0;
      smp_cyc = cyc;
      repeat (3) @(negedge clk);
   endtask

   // Runs one capture of seq_q; trig_idx is the sample the trigger rule must fire on.
   task automatic run_capture(input string tag, input int trig_idx, input logic mode,
                              input logic [DW-1:0] lvl, input int sbf_at, input int start_at,
                              input bit rdy_with_start);
      int start_cyc, trig_cyc;
      trig_mode  = mode;
      trig_level = lvl;
      trig_cyc   = 0;
      @(negedge clk);
      start = 1'b1;
      if (rdy_with_start) begin
         adc_rdy  = 1'b1;
         adc_data = 8'hEE;
      end
      @(negedge clk);
      start     = 1'b0;
      adc_rdy   = 1'b0;
      start_cyc = cyc;
      check_eq({tag, "_arm_trd"}, trd, 0);
      check_eq({tag, "_arm_cd"}, cd, 0);
      check_eq({tag, "_arm_trigtm"}, trigtm, 0);
      check_eq({tag, "_arm_busy"}, busy, 1);
      for (int i = 0; i < seq_q.size(); i++) begin
         drive_sample(seq_q[i]);
         if (i == trig_idx) trig_cyc = smp_cyc;
         if (i == PR - 1) check_eq({tag, "_fill_notrig"}, trd, 0);
         if (i == trig_idx - 1) check_eq({tag, "_pre_trd"}, trd, 0);
         if (i == trig_idx) check_eq({tag, "_trd"}, trd, 1);
         if (i == sbf_at) begin
            sbf = 1'b1;
            @(negedge clk);
            sbf = 1'b0;
            @(negedge clk);
            check_eq({tag, "_sbf_ignored"}, sd_valid, 0);
         end
         if (i == start_at) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq({tag, "_start_ign_trd"}, trd, 1);
            check_eq({tag, "_start_ign_busy"}, busy, 1);
         end
      end
      check_eq({tag, "_hold_busy"}, busy, 0);
      check_eq({tag, "_hold_trd"}, trd, 1);
      check_eq({tag, "_trigtm"}, trigtm, 64'(trig_cyc - start_cyc - 1));
      for (int k = 0; k < DEP; k++) exp_q.push_back(seq_q[trig_idx - PR + k]);
   endtask

   task automatic recv(input string tag);
      int nbits;
      logic [DW-1:0] w;
      logic [DW-1:0] e;
      nbits = 0;
      w     = '0;
      @(negedge clk);
      sbf = 1'b1;
      @(negedge clk);
      sbf = 1'b0;
      while (sd_valid && nbits < 300) begin
         w = {w[DW-2:0], sd};
         nbits++;
         if (nbits % DW == 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            check_eq($sformatf("%s_w%0d", tag, nbits / DW - 1), w, e);
         end
         @(negedge clk);
      end
      check_eq({tag, "_nbits"}, nbits, DEP * DW);
      check_eq({tag, "_cd"}, cd, 1);
      check_eq({tag, "_sd_idle"}, sd, 0);
      check_eq({tag, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      #2;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_trd", trd, 0);
      check_eq("rst_sdv", sd_valid, 0);
      check_eq("rst_sd", sd, 0);
      check_eq("rst_cd", cd, 0);
      check_eq("rst_trigtm", trigtm, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: level trigger on a ramp
      seq_q.delete();
      for (int i = 0; i <= 8'hD4 + 15; i++) seq_q.push_back(8'(i));
      run_capture("t1", 8'hD4, 1'b0, 8'hD4, -1, -1, 1'b0);
      recv("t1");

      // 2: rising crossing, F0 during fill must not count as a crossing
      seq_q.delete();
      for (int i = 0; i < PR; i++) seq_q.push_back(8'hF0);
      seq_q.push_back(8'h10);
      seq_q.push_back(8'h90);
      for (int i = 0; i < DEP - PR - 1; i++) seq_q.push_back(8'(8'hA0 + i));
      run_capture("t2", PR + 1, 1'b1, 8'h80, -1, -1, 1'b0);
      recv("t2");

      // 3: long armed phase wraps the ring several times
      seq_q.delete();
      for (int i = 0; i <= 125; i++) seq_q.push_back((i == 110) ? 8'hF0 : 8'(i));
      run_capture("t3", 110, 1'b0, 8'hF0, -1, -1, 1'b0);
      recv("t3");

      // 4: sbf while armed and start while in post are both ignored; then send twice
      seq_q.delete();
      for (int i = 0; i < PR + 8; i++) seq_q.push_back(8'(8'h30 + i));
      seq_q.push_back(8'h99);
      for (int i = 0; i < DEP - PR - 1; i++) seq_q.push_back(8'(8'hC0 + i));
      run_capture("t4", PR + 8, 1'b0, 8'h80, PR + 2, PR + 11, 1'b0);
      recv("t4a");
      for (int k = 0; k < DEP; k++) exp_q.push_back(seq_q[PR + 8 - PR + k]);
      check_eq("t4_cd_held", cd, 1);
      recv("t4b");

      // 5: async reset in the middle of a send
      for (int k = 0; k < DEP; k++) exp_q.push_back(seq_q[8 + k]);
      @(negedge clk);
      sbf = 1'b1;
      @(negedge clk);
      sbf = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("t5_mid_sdv", sd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5_rst_sd", sd, 0);
      check_eq("t5_rst_sdv", sd_valid, 0);
      check_eq("t5_rst_trd", trd, 0);
      check_eq("t5_rst_cd", cd, 0);
      check_eq("t5_rst_trigtm", trigtm, 0);
      check_eq("t5_rst_busy", busy, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seq_q.delete();
      for (int i = 0; i < PR; i++) seq_q.push_back(8'(8'h05 + i));
      seq_q.push_back(8'hB7);
      for (int i = 0; i < DEP - PR - 1; i++) seq_q.push_back(8'(8'h60 + i));
      run_capture("t5", PR, 1'b0, 8'hB0, -1, -1, 1'b0);
      recv("t5");

      // 6: start with a coincident adc_rdy in HOLD; that sample must be dropped
      seq_q.delete();
      for (int i = 0; i < PR; i++) seq_q.push_back(8'(8'h20 + i));
      seq_q.push_back(8'h30);
      seq_q.push_back(8'h40);
      seq_q.push_back(8'h90);
      for (int i = 0; i < DEP - PR - 1; i++) seq_q.push_back(8'(8'h50 + i));
      run_capture("t6", PR + 2, 1'b0, 8'h80, -1, -1, 1'b1);
      recv("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
